// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer: y = a when s = 0, b when s = 1.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Pure combinational select, no state.
  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a shared WIDTH-bit 2:1 mux.
// Grants, select and round-robin pointer are registered; the data path
// from d0/d1 to z is purely combinational.
// Optional hold timeout is enabled by defining MUX2_ARB_TIMEOUT_EN; the
// default build holds a grant for as long as its owner keeps requesting.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] z,
  output logic             z_valid
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       prio_q;
  logic       sel_q;
  logic       hold_expired;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;

  // Hold counter: cleared on any state change, counts owned cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != IDLE && cnt_q != HOLD_LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hold_expired = (cnt_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // Next-state decision: tie-break by prio in IDLE, hand over directly
  // between owners, and force a hand-over when the hold time is used up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = prio_q ? OWN1 : OWN0;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        if (hold_expired && req1) state_d = OWN1;
        else if (!req0)           state_d = req1 ? OWN1 : IDLE;
      end
      OWN1: begin
        if (hold_expired && req0) state_d = OWN0;
        else if (!req1)           state_d = req0 ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and sticky select register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == OWN0 && state_d != OWN0) prio_q <= 1'b1;
      if (state_q == OWN1 && state_d != OWN1) prio_q <= 1'b0;
      if (state_d == OWN0)      sel_q <= 1'b0;
      else if (state_d == OWN1) sel_q <= 1'b1;
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign z_valid = gnt0 | gnt1;
  assign sel     = sel_q;

  // One mux2 per data bit, all steered by the registered select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_mux2 (
      .a (d0[i]),
      .b (d1[i]),
      .s (sel_q),
      .y (z[i])
    );
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter (WIDTH=4, MAX_HOLD=4).
// The hold-timeout expectations follow MUX2_ARB_TIMEOUT_EN if defined.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] d0, d1;
  logic       gnt0, gnt1, sel, z_valid;
  logic [3:0] z;

  int checks = 0;
  int fails  = 0;

  mux2_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .z       (z),
    .z_valid (z_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant outputs as one word {gnt1, gnt0}; also checks mutual exclusion.
  task automatic chk_gnt(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, gnt1, gnt0}, {30'd0, exp});
    chk({tag, "_excl"}, {31'd0, gnt0 & gnt1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 4'h0; d1 = 4'h0;

    // Reset state
    tick(); tick();
    chk_gnt("rst_gnt", 2'b00);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_zv", {31'd0, z_valid}, 32'd0);

    // Single request
    rst = 1'b0; req0 = 1'b1; d0 = 4'h1; d1 = 4'h0;
    tick();
    chk_gnt("single_gnt", 2'b01);
    chk("single_sel", {31'd0, sel}, 32'd0);
    chk("single_z", {28'd0, z}, 32'h1);
    chk("single_zv", {31'd0, z_valid}, 32'd1);
    tick(); tick();
    chk_gnt("single_hold", 2'b01);
    req0 = 1'b0;
    tick();
    chk_gnt("single_release", 2'b00);
    chk("single_release_zv", {31'd0, z_valid}, 32'd0);

    // Tie after reset: requester 0 wins, then direct hand-over to 1
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
    tick();
    chk_gnt("tie_gnt", 2'b01);
    chk("tie_z", {28'd0, z}, 32'h3);
    req0 = 1'b0;
    tick();
    chk_gnt("handover_gnt", 2'b10);
    chk("handover_sel", {31'd0, sel}, 32'd1);
    chk("handover_z", {28'd0, z}, 32'hC);

    // Round-robin alternation
    req0 = 1'b1;
    tick();
    chk_gnt("rr_hold1", 2'b10);
    req1 = 1'b0;
    tick();
    chk_gnt("rr_to0", 2'b01);
    chk("rr_to0_sel", {31'd0, sel}, 32'd0);
    req1 = 1'b1; req0 = 1'b0;
    tick();
    chk_gnt("rr_to1", 2'b10);
    req0 = 1'b1; req1 = 1'b0;
    tick();
    chk_gnt("rr_to0b", 2'b01);
    req1 = 1'b1; req0 = 1'b0;
    tick();
    chk_gnt("rr_to1b", 2'b10);

    // Reset mid-grant
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk_gnt("pre_rst_gnt", 2'b10);
    chk("pre_rst_sel", {31'd0, sel}, 32'd1);
    rst = 1'b1;
    tick();
    chk_gnt("midrst_gnt", 2'b00);
    chk("midrst_sel", {31'd0, sel}, 32'd0);
    chk("midrst_zv", {31'd0, z_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk_gnt("post_rst_tie", 2'b01);

    // Tie in IDLE after owner 0 exits: pointer names requester 1
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_gnt("rr_idle", 2'b00);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk_gnt("rr_tie_prio1", 2'b10);

    // Sticky select in IDLE, z tracks d1 combinationally
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_gnt("sticky_idle", 2'b00);
    chk("sticky_sel", {31'd0, sel}, 32'd1);
    chk("sticky_zv", {31'd0, z_valid}, 32'd0);
    d1 = 4'h5; d0 = 4'hA; #1;
    chk("sticky_z_a", {28'd0, z}, 32'h5);
    d1 = 4'h9; d0 = 4'h6; #1;
    chk("sticky_z_b", {28'd0, z}, 32'h9);

    // Hold timeout behaviour under contention
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0;
    tick();
    chk_gnt("to_start", 2'b01);
    req1 = 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt("to_hold0", 2'b01);
    end
    tick();
    chk_gnt("to_force1", 2'b10);
`else
    for (int i = 0; i < 22; i++) begin
      tick();
      chk_gnt("nto_hold0", 2'b01);
    end
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
